// File: rtl/conv_window_gen_5x5.sv
// conv_window_gen_5x5: raster pixel stream to 5x5 sliding window for the conv PE.
// Four line buffers hold the previous lines; a 5x5 register array holds the window.
// Optional macro OUT_COORD_EN adds out_row/out_col output-map coordinates.
module conv_window_gen_5x5 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sof,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     pix_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [25*DATA_W-1:0]  win_out,
    output logic                  frame_done
`ifdef OUT_COORD_EN
    ,
    output logic [9:0]            out_row,
    output logic [9:0]            out_col
`endif
);

    localparam int unsigned K     = 5;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    // lb[0] is the most recent line, lb[3] the oldest
    logic [DATA_W-1:0] lb  [4][IMG_W];
    logic [DATA_W-1:0] win [K][K];

    logic [COL_W-1:0] col, col_eff;
    logic [ROW_W-1:0] row, row_eff;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             win_hit;

    // Handshake and effective position (sof forces the pixel to (0,0))
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        col_eff  = sof ? '0 : col;
        row_eff  = sof ? '0 : row;
        last_col = (col_eff == COL_W'(IMG_W - 1));
        last_row = (row_eff == ROW_W'(IMG_H - 1));
        win_hit  = (row_eff >= ROW_W'(4)) && (col_eff >= COL_W'(4));
    end

    // Line-buffer column shift on every accepted pixel (not reset: output is valid-gated)
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[3][col_eff] <= lb[2][col_eff];
            lb[2][col_eff] <= lb[1][col_eff];
            lb[1][col_eff] <= lb[0][col_eff];
            lb[0][col_eff] <= pix_in;
        end
    end

    // Window shift, position counters, output valid and frame-done pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            frame_done <= accept && last_row && last_col;
            if (accept) begin
                for (int unsigned i = 0; i < K; i++) begin
                    for (int unsigned j = 0; j < K - 1; j++) begin
                        win[i][j] <= win[i][j+1];
                    end
                end
                win[0][K-1] <= lb[3][col_eff];
                win[1][K-1] <= lb[2][col_eff];
                win[2][K-1] <= lb[1][col_eff];
                win[3][K-1] <= lb[0][col_eff];
                win[4][K-1] <= pix_in;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row_eff + ROW_W'(1);
                end else begin
                    col <= col_eff + COL_W'(1);
                    row <= row_eff;
                end
            end
            if (accept && win_hit) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef OUT_COORD_EN
    // Output-map coordinate of the window being loaded; holds while stalled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_row <= '0;
            out_col <= '0;
        end else if (accept && win_hit) begin
            out_row <= 10'(row_eff) - 10'd4;
            out_col <= 10'(col_eff) - 10'd4;
        end
    end
`endif

    // Flatten window row-major: byte k is p(k+1), p1 top-left
    always_comb begin
        win_out = '0;
        for (int unsigned k = 0; k < K * K; k++) begin
            win_out[k*DATA_W +: DATA_W] = win[k/K][k%K];
        end
    end

endmodule
